// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised parallel-to-serial converter.
package serializer_pkg;

   localparam int unsigned SER_DATA_W = 16;
   localparam int unsigned SER_LEN_W  = $clog2(SER_DATA_W + 1);

   typedef logic [SER_DATA_W-1:0] ser_word_t;
   typedef logic [SER_LEN_W-1:0]  ser_len_t;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   // A requested length of 0, or one wider than the word, means "send the whole word".
   function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_w);
      return ((len == 0) || (len > max_w)) ? max_w : len;
   endfunction

endpackage

// File: rtl/ser_shift_core.sv
// Shifter for one word: bit register, remaining-bit down-counter and first/last flags.
// A load always wins over an advance, so a new word can follow the last bit with no gap.
module ser_shift_core
   import serializer_pkg::*;
#(
   parameter int DATA_W = SER_DATA_W,
   parameter int LEN_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic [LEN_W-1:0]  load_len_i,
   input  logic              load_lsb_i,
   output logic              active_o,
   output logic              ser_data_o,
   output logic              ser_first_o,
   output logic              ser_last_o
);

   ser_state_e        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              lsb_q, lsb_d;
   logic              first_q, first_d;
   logic [LEN_W-1:0]  msb_shift;
   logic              cur_bit;

   // Next-state logic: load a new word, or step one bit towards the end of the current one.
   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      lsb_d     = lsb_q;
      first_d   = first_q;
      msb_shift = LEN_W'(DATA_W) - load_len_i;
      if (load_i) begin
         state_d = SER_SHIFT;
         // MSB-first words are left-aligned so the outgoing bit is always the top bit.
         shreg_d = load_lsb_i ? load_data_i : (load_data_i << msb_shift);
         cnt_d   = load_len_i;
         lsb_d   = load_lsb_i;
         first_d = 1'b1;
      end else if (advance_i && (state_q == SER_SHIFT)) begin
         first_d = 1'b0;
         if (cnt_q == LEN_W'(1)) begin
            state_d = SER_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
         end
      end
   end

   // State registers, cleared asynchronously so a reset drops the word immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst_i) begin
         state_q <= SER_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         lsb_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         lsb_q   <= lsb_d;
         first_q <= first_d;
      end
   end

   assign cur_bit     = lsb_q ? shreg_q[0] : shreg_q[DATA_W-1];
   assign active_o    = (state_q == SER_SHIFT);
   assign ser_data_o  = active_o & cur_bit;
   assign ser_first_o = active_o & first_q;
   assign ser_last_o  = active_o & (cnt_q == LEN_W'(1));

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with valid/ready input, per-word length and bit order,
// and a one-word pending buffer so consecutive words stream without idle bits.
module param_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W = SER_DATA_W,
   parameter int LEN_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  data_len_i,
   input  logic              lsb_first_i,
   input  logic              data_val_i,
   output logic              data_rdy_o,
   output logic              ser_data_o,
   output logic              ser_val_o,
   output logic              ser_first_o,
   output logic              ser_last_o,
   output logic              busy_o
);

   logic [DATA_W-1:0] pend_data_q, pend_data_d;
   logic [LEN_W-1:0]  pend_len_q, pend_len_d;
   logic              pend_lsb_q, pend_lsb_d;
   logic              pend_full_q, pend_full_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;

   logic              accept, shifter_free;
   logic [LEN_W-1:0]  in_len;
   logic              load;
   logic [DATA_W-1:0] load_data;
   logic [LEN_W-1:0]  load_len;
   logic              load_lsb;
   logic              active, last_bit;

   assign accept       = data_val_i & rdy_q;
   assign shifter_free = ~active | last_bit;
   assign in_len       = LEN_W'(eff_len(32'(data_len_i), DATA_W));

   // Route each word: drain pending first, else bypass into a free shifter, else park it.
   always_comb begin
      pend_data_d = pend_data_q;
      pend_len_d  = pend_len_q;
      pend_lsb_d  = pend_lsb_q;
      pend_full_d = pend_full_q;
      load        = 1'b0;
      load_data   = data_i;
      load_len    = in_len;
      load_lsb    = lsb_first_i;
      if (shifter_free && pend_full_q) begin
         load        = 1'b1;
         load_data   = pend_data_q;
         load_len    = pend_len_q;
         load_lsb    = pend_lsb_q;
         pend_full_d = 1'b0;
      end else if (shifter_free && accept) begin
         load = 1'b1;
      end else if (accept) begin
         pend_data_d = data_i;
         pend_len_d  = in_len;
         pend_lsb_d  = lsb_first_i;
         pend_full_d = 1'b1;
      end
      // Ready and busy come only from next-state terms, so both outputs are plain flops.
      rdy_d  = ~pend_full_d;
      busy_d = load | (active & ~last_bit) | pend_full_d;
   end

   // Pending buffer and handshake flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: the pending word is a handful of flops, so it is reset along with the control state.
      if (rst_i) begin
         pend_data_q <= '0;
         pend_len_q  <= '0;
         pend_lsb_q  <= 1'b0;
         pend_full_q <= 1'b0;
         rdy_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         pend_data_q <= pend_data_d;
         pend_len_q  <= pend_len_d;
         pend_lsb_q  <= pend_lsb_d;
         pend_full_q <= pend_full_d;
         rdy_q       <= rdy_d;
         busy_q      <= busy_d;
      end
   end

   ser_shift_core #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_core (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load),
      .advance_i   (active),
      .load_data_i (load_data),
      .load_len_i  (load_len),
      .load_lsb_i  (load_lsb),
      .active_o    (active),
      .ser_data_o  (ser_data_o),
      .ser_first_o (ser_first_o),
      .ser_last_o  (last_bit)
   );

   assign ser_last_o = last_bit;
   assign ser_val_o  = active;
   assign data_rdy_o = rdy_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer (DATA_W=16): a bit-stream model compared every cycle,
// plus directed scenarios with hand-computed streams and timing.
module tb_param_serializer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] data_i;
   logic [4:0]  data_len_i;
   logic        lsb_first_i;
   logic        data_val_i;
   logic        data_rdy_o, ser_data_o, ser_val_o, ser_first_o, ser_last_o, busy_o;

   param_serializer #(.DATA_W(16), .LEN_W(5)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .data_i      (data_i),
      .data_len_i  (data_len_i),
      .lsb_first_i (lsb_first_i),
      .data_val_i  (data_val_i),
      .data_rdy_o  (data_rdy_o),
      .ser_data_o  (ser_data_o),
      .ser_val_o   (ser_val_o),
      .ser_first_o (ser_first_o),
      .ser_last_o  (ser_last_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the queue of bits still owed on the serial line. The line must show the head
   // bit each cycle with no gaps; more than one whole word owed means the buffer is full.
   typedef struct packed {logic b; logic f; logic l;} ebit_t;
   ebit_t mq[$];

   function automatic void push_word(input logic [15:0] d, input logic [4:0] len, input logic lsb);
      int n = ((len == 0) || (len > 16)) ? 16 : int'(len);
      for (int k = 0; k < n; k++) begin
         int idx = lsb ? k : (n - 1 - k);
         mq.push_back('{b: d[idx], f: (k == 0), l: (k == n - 1)});
      end
   endfunction

   always @(negedge clk_i) begin : cmp_blk
      logic [5:0] exp_v, act_v;
      int words;
      if (rst_i) mq.delete();
      words = 0;
      foreach (mq[k]) if (mq[k].l) words++;
      if (mq.size() > 0) exp_v = {1'b1, mq[0].b, mq[0].f, mq[0].l, (words <= 1), 1'b1};
      else               exp_v = 6'b000010;
      act_v = {ser_val_o, ser_data_o, ser_first_o, ser_last_o, data_rdy_o, busy_o};
      check("cycle_outputs{val,data,first,last,rdy,busy}", 64'(act_v), 64'(exp_v));
      if (!rst_i) begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (data_val_i && data_rdy_o) push_word(data_i, data_len_i, lsb_first_i);
      end
   end

   // Observation of the serial line and handshake edges for the directed checks.
   logic [63:0] log_bits = '0;
   int          log_n = 0, run_len = 0, max_run = 0, busy_fall_cyc = -1;
   logic        busy_prev = 1'b0, rdy_prev = 1'b1;
   int          rdy_fall_q[$], rdy_rise_q[$];

   always @(negedge clk_i) begin
      if (ser_val_o) begin
         log_bits = {log_bits[62:0], ser_data_o};
         log_n++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
      if (busy_prev && !busy_o) busy_fall_cyc = cyc;
      if (rdy_prev && !data_rdy_o) rdy_fall_q.push_back(cyc);
      if (!rdy_prev && data_rdy_o) rdy_rise_q.push_back(cyc);
      busy_prev = busy_o;
      rdy_prev  = data_rdy_o;
   end

   task automatic clear_log();
      log_bits = '0;
      log_n    = 0;
      max_run  = 0;
      rdy_fall_q.delete();
      rdy_rise_q.delete();
   endtask

   // Offer a word and hold it until accepted; returns the cycle number of the accepting edge.
   task automatic send(input logic [15:0] d, input logic [4:0] len, input logic lsb, output int acc_c);
      data_i      = d;
      data_len_i  = len;
      lsb_first_i = lsb;
      data_val_i  = 1'b1;
      acc_c       = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (data_rdy_o) begin
            @(posedge clk_i);
            #1;
            acc_c = cyc;
            break;
         end
      end
      check("send_accepted", 64'(acc_c >= 0), 64'd1);
      data_val_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (!busy_o) break;
      end
      check("idle_reached", 64'(busy_o), 64'd0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a2, a3, b, acc_c, i;
      logic [15:0] acc_word;

      rst_i = 1'b1; data_i = '0; data_len_i = '0; lsb_first_i = 1'b0; data_val_i = 1'b0;
      // Reset with no clock edge yet.
      #2;
      check("reset_val", 64'(ser_val_o), 64'd0);
      check("reset_data", 64'(ser_data_o), 64'd0);
      check("reset_first", 64'(ser_first_o), 64'd0);
      check("reset_last", 64'(ser_last_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_rdy", 64'(data_rdy_o), 64'd1);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // First bit one cycle after the accept.
      send(16'hFFFF, 5'd16, 1'b0, a);
      @(negedge clk_i);
      check("first_bit_latency{val,first,data}", 64'({ser_val_o, ser_first_o, ser_data_o}), 64'h7);
      wait_idle();

      // MSB-first full word.
      clear_log();
      send(16'hA5C3, 5'd16, 1'b0, a);
      wait_idle();
      check("msb_a5c3_bits", 64'(log_bits[15:0]), 64'h1010_0101_1100_0011 >> 0 == 0 ? 0 : 64'hA5C3);
      check("msb_a5c3_count", 64'(log_n), 64'd16);

      // LSB-first, 5 bits of 0x0016: 0,1,1,0,1.
      clear_log();
      send(16'h0016, 5'd5, 1'b1, a);
      wait_idle();
      check("lsb_len5_bits", 64'(log_bits[4:0]), 64'b01101);
      check("lsb_len5_count", 64'(log_n), 64'd5);

      // Length 0 means the full word; LSB-first 0x1234 reversed is 0x2C48.
      clear_log();
      send(16'h1234, 5'd0, 1'b1, a);
      wait_idle();
      check("len0_bits", 64'(log_bits[15:0]), 64'h2C48);
      check("len0_count", 64'(log_n), 64'd16);

      // Length 1: first and last together.
      clear_log();
      send(16'h0001, 5'd1, 1'b1, a);
      @(negedge clk_i);
      check("len1_flags{val,first,last,data}", 64'({ser_val_o, ser_first_o, ser_last_o, ser_data_o}), 64'hF);
      wait_idle();
      check("len1_count", 64'(log_n), 64'd1);

      // Length above DATA_W means the full word.
      clear_log();
      send(16'hBEEF, 5'd20, 1'b0, a);
      wait_idle();
      check("len20_bits", 64'(log_bits[15:0]), 64'hBEEF);
      check("len20_count", 64'(log_n), 64'd16);

      // Short MSB-first word: upper bits ignored, 0xFFF5 len 3 gives 1,0,1.
      clear_log();
      send(16'hFFF5, 5'd3, 1'b0, a);
      wait_idle();
      check("len3_bits", 64'(log_bits[2:0]), 64'b101);
      check("len3_count", 64'(log_n), 64'd3);

      // Back-to-back: three 16-bit words with valid held.
      clear_log();
      send(16'hF00D, 5'd16, 1'b0, a1);
      send(16'h3C01, 5'd16, 1'b1, a2);
      send(16'h8001, 5'd16, 1'b0, a3);
      wait_idle();
      check("b2b_run", 64'(max_run), 64'd48);
      check("b2b_count", 64'(log_n), 64'd48);
      check("b2b_bits", 64'(log_bits[47:0]), 64'hF00D_803C_8001);
      check("b2b_accept2", 64'(a2), 64'(a1 + 1));
      check("b2b_accept3", 64'(a3), 64'(a1 + 17));
      check("b2b_rdy_fall", 64'((rdy_fall_q.size() > 0) ? rdy_fall_q[0] : -1), 64'(a2));
      check("b2b_rdy_rise", 64'((rdy_rise_q.size() > 0) ? rdy_rise_q[0] : -1), 64'(a1 + 16));
      check("b2b_busy_fall", 64'(busy_fall_cyc), 64'(a1 + 48));

      // Reset at bit 7 with a word pending.
      clear_log();
      send(16'hFFFF, 5'd16, 1'b0, a);
      send(16'hFFFF, 5'd16, 1'b0, b);
      repeat (5) @(posedge clk_i);
      #1;
      check("pre_reset_busy{val,rdy,busy}", 64'({ser_val_o, data_rdy_o, busy_o}), 64'b101);
      rst_i = 1'b1;
      #1;
      check("mid_reset_outputs{val,data,first,last,rdy,busy}",
            64'({ser_val_o, ser_data_o, ser_first_o, ser_last_o, data_rdy_o, busy_o}), 64'b000010);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      clear_log();
      repeat (40) @(posedge clk_i);
      #1;
      check("post_reset_leftover_bits", 64'(log_n), 64'd0);
      check("post_reset_busy", 64'(busy_o), 64'd0);

      // Stall: valid held with changing data while the buffer is full.
      clear_log();
      send(16'h00FF, 5'd16, 1'b0, a);
      send(16'h5A5A, 5'd16, 1'b0, b);
      acc_c = -1;
      acc_word = '0;
      data_len_i = 5'd16;
      lsb_first_i = 1'b0;
      data_val_i = 1'b1;
      i = 0;
      while (i < 100) begin
         data_i = 16'h1000 + 16'(i);
         @(negedge clk_i);
         if (data_rdy_o) begin
            acc_word = data_i;
            @(posedge clk_i);
            #1;
            acc_c = cyc;
            break;
         end
         @(posedge clk_i);
         #1;
         i++;
      end
      data_val_i = 1'b0;
      wait_idle();
      check("stall_accept_cycle", 64'(acc_c), 64'(a + 17));
      check("stall_count", 64'(log_n), 64'd48);
      check("stall_bits", 64'(log_bits[47:0]), {16'h0, 16'h00FF, 16'h5A5A, acc_word});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_serializer.md
Name: param_serializer

Overview:
- Parametrised parallel-to-serial converter. Successor to the fixed 6-bit serializer.
- Adds generic width, per-word bit length, runtime MSB/LSB-first order and a valid/ready input handshake.
- A one-word pending buffer lets back-to-back words stream with no idle bit between them.
- Sits between a word-oriented producer (register block or FIFO) and a single-wire serial line or encoder.

Parameters:
- DATA_W, 16: maximum word width in bits; legal range 2..64.
- LEN_W, $clog2(DATA_W+1): width of the length field.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  DATA_W  parallel word.
- data_len_i  input  LEN_W  number of bits to send; 0 or >DATA_W means DATA_W.
- lsb_first_i  input  1  per-word order: 0 = MSB first, 1 = LSB first.
- data_val_i  input  1  word valid.
- data_rdy_o  output  1  block can accept a word; registered.
- ser_data_o  output  1  serial bit; 0 whenever ser_val_o=0.
- ser_val_o  output  1  ser_data_o carries a valid bit.
- ser_first_o  output  1  first bit of a word.
- ser_last_o  output  1  last bit of a word.
- busy_o  output  1  a word is shifting or pending.

Behaviour:
- Reset: when rst_i=1, all state clears at once, without waiting for a clock.
  - Reset values: data_rdy_o=1; ser_data_o, ser_val_o, ser_first_o, ser_last_o and busy_o = 0.
  - Shift, pending and counter registers clear.
  - Reset mid-word drops the current and pending words; no partial output follows.
- Transfer: a word is accepted on a rising edge where data_val_i=1 and data_rdy_o=1. Inputs are ignored otherwise.
- Length: the effective length L is resolved at accept time. data_len_i=0 or >DATA_W gives L=DATA_W.
  - MSB-first sends data_i[L-1] down to data_i[0].
  - LSB-first sends data_i[0] up to data_i[L-1].
  - Bits above L-1 are ignored.
  - lsb_first_i is latched with the word.
- Internal state: a shifter (bit register, down-counter, active flag) plus a pending buffer (word, L, order, full flag).
- Latency: a word accepted at edge N into an idle shifter presents its first bit with ser_val_o=1 and ser_first_o=1 in the cycle after edge N. One bit follows per clock.
  - ser_last_o=1 on bit L. ser_first_o and ser_last_o are both 1 when L=1.
- Shifter state machine:
  - IDLE: ser_val_o=0. An accept or a full pending buffer moves it to SHIFT.
  - SHIFT: on the last bit, load pending (or a bypass accept) and stay in SHIFT; if nothing is available, go to IDLE.
- Accept routing:
  - Shifter idle, or on its last bit, with pending empty: the word loads directly into the shifter (bypass), so there is no gap.
  - Shifter busy with further bits to send: the word goes to pending, and data_rdy_o falls at the next edge.
- Pending drain: on the shifter's last bit, pending moves to the shifter and data_rdy_o rises at the next edge.
  - No combinational path runs from the shifter to data_rdy_o.
  - No accept is possible in the drain cycle.
- busy_o = shifter active OR pending full; registered, with no extra latency.
- Counter arithmetic: LEN_W bits, counting down to 1. It never wraps, because L ≥ 1 is guaranteed by the length rule.

Decomposition:
- Shared package serializer_pkg holds:
  - typedef ser_word_t (logic [DATA_W-1:0]);
  - typedef ser_len_t;
  - enum ser_state_e {SER_IDLE, SER_SHIFT};
  - function eff_len() implementing the length rule.
- One sub-module, ser_shift_core: the shifter plus counter plus first/last flags, with load and advance inputs.
- The top level holds the pending buffer and the handshake logic.

Test Plan:
- Reset: with rst_i=1 and no clock edge, outputs are 0 and data_rdy_o=1. Release, accept 0xFFFF → first bit appears 1 cycle after the accept.
- MSB-first, DATA_W=16: data 0xA5C3, len 16 → ser_data 1010010111000011 over 16 cycles, ser_first on bit 1, ser_last on bit 16, then ser_val_o=0.
- LSB-first: data 0x0016, len 5 → bits 0,1,1,0,1; a following len=0 word sends 16 bits; a len=1 word asserts ser_first and ser_last in the same cycle.
- Back-to-back: three len-16 words with data_val_i held →
  - ser_val_o stays high for 48 continuous cycles;
  - data_rdy_o is low from the edge after word 2 is accepted until the edge after word 2 drains to the shifter;
  - busy_o falls after bit 48.
- Reset mid-operation: assert rst_i at bit 7 of a word with another word pending → outputs clear immediately, and after release no leftover bits appear.
- Stall: data_val_i=1 while data_rdy_o=0 with a changing data_i → the held word is unaffected and the new word is accepted only when data_rdy_o=1.
